// File: rtl/mod12_cmd_seq.sv
// mod12_cmd_seq: FIFO-buffered command sequencer driving a mod-12 counter; `MOD12_SEQ_PREDICT_EN adds a counter-value predictor
module mod12_cmd_seq #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_arg,
  output logic       load,
  output logic       mode,
  output logic [3:0] data_in,
  input  logic [3:0] data_out,
  output logic       busy,
  output logic       err_illegal,
  output logic [3:0] exp_count,
  output logic       mismatch_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, LD, RUN, ILL} state_t;
  state_t state_q, state_d;
  logic [5:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_q, rd_q;
  logic [3:0] run_cnt_q, run_cnt_d, data_in_q, data_in_d;
  logic load_q, load_d, mode_q, mode_d, err_q, err_d;
  logic empty, full, push, pop, last, is_ld, is_run;
  logic [1:0] h_op;
  logic [3:0] h_arg;
  assign empty = wr_q == rd_q;
  assign full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign cmd_ready = !reset && !full;
  assign push = cmd_valid && cmd_ready;
  assign {h_op, h_arg} = mem_q[rd_q[AW-1:0]];
  assign is_ld = (h_op == 2'b00) && (h_arg <= 4'd11);
  assign is_run = (h_op == 2'b01) || (h_op == 2'b10);
  assign last = (state_q == LD) || (state_q == ILL) || (state_q == RUN && run_cnt_q == 4'd0);
  assign pop = !empty && (state_q == IDLE || last);
  assign busy = (state_q != IDLE) || !empty;
  assign load = load_q;
  assign mode = mode_q;
  assign data_in = data_in_q;
  assign err_illegal = err_q;
  // FIFO storage; entries are not reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= {cmd_op, cmd_arg};
  end
  // FIFO pointers; reset flushes queued commands
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push);
      rd_q <= rd_q + (AW+1)'(pop);
    end
  end
  // next command is decoded at pop so the drive registers change on the same edge
  always_comb begin
    state_d = last ? IDLE : state_q;
    run_cnt_d = (state_q == RUN) ? run_cnt_q - 4'd1 : run_cnt_q;
    load_d = 1'b0;
    mode_d = mode_q;
    data_in_d = data_in_q;
    err_d = err_q;
    if (pop) begin
      state_d = is_ld ? LD : is_run ? RUN : ILL;
      run_cnt_d = h_arg;
      load_d = is_ld;
      mode_d = is_run ? (h_op == 2'b01) : mode_q;
      data_in_d = is_ld ? h_arg : data_in_q;
      err_d = err_q || (!is_ld && !is_run);
    end
  end
  // FSM and registered counter drive
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      run_cnt_q <= '0;
      load_q <= 1'b0;
      mode_q <= 1'b1;
      data_in_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_cnt_q <= run_cnt_d;
      load_q <= load_d;
      mode_q <= mode_d;
      data_in_q <= data_in_d;
      err_q <= err_d;
    end
  end
`ifdef MOD12_SEQ_PREDICT_EN
  logic [3:0] exp_q, exp_d;
  logic mism_q;
  assign exp_count = exp_q;
  assign mismatch_err = mism_q;
  // mirror of the counter: the prediction follows the drive this block issued
  always_comb exp_d = load_q ? data_in_q : mode_q ? ((exp_q == 4'd11) ? 4'd0 : exp_q + 4'd1) : ((exp_q == 4'd0) ? 4'd11 : exp_q - 4'd1);
  // predicted value and sticky divergence flag
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_q <= '0;
      mism_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      mism_q <= mism_q || (data_out != exp_q);
    end
  end
`else
  logic unused_data_out;
  assign unused_data_out = ^data_out;
  assign exp_count = 4'd0;
  assign mismatch_err = 1'b0;
`endif
endmodule

// File: tb/tb_mod12_cmd_seq.sv
// tb_mod12_cmd_seq: randomized bench for mod12_cmd_seq against a command-expansion reference model
module tb_mod12_cmd_seq;
  localparam int D = 4;
`ifdef MOD12_SEQ_PREDICT_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_op = '0;
  logic [3:0] cmd_arg = '0, data_out = '0;
  logic cmd_ready, load, mode, busy, err_illegal, mismatch_err;
  logic [3:0] data_in, exp_count;
  int n_chk = 0, n_err = 0;
  int q[$];
  int rem = 0, m_data = 0, cnt = 0;
  bit m_load = 0, m_mode = 1, m_err = 0, m_mism = 0, glitch = 0;

  mod12_cmd_seq #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .load(load), .mode(mode), .data_in(data_in),
    .data_out(data_out), .busy(busy), .err_illegal(err_illegal),
    .exp_count(exp_count), .mismatch_err(mismatch_err)
  );

  always #5 clk = ~clk;

  // reference: each command expands into a number of drive cycles; cnt models a correct counter
  always @(posedge clk) begin
    bit pre_ready, pop_ok;
    int c, op, arg;
    if (reset) begin
      q.delete();
      rem = 0; m_load = 0; m_mode = 1; m_data = 0; m_err = 0; cnt = 0; m_mism = 0;
    end else begin
      pre_ready = q.size() < D;
      pop_ok = rem <= 1 && q.size() > 0;
      if (PRED && int'(data_out) != cnt) m_mism = 1;
      cnt = m_load ? m_data : m_mode ? (cnt + 1) % 12 : (cnt + 11) % 12;
      if (rem > 0) rem--;
      m_load = 0;
      if (pop_ok) begin
        c = q.pop_front();
        op = c / 16;
        arg = c % 16;
        if (op == 0 && arg < 12) begin rem = 1; m_load = 1; m_data = arg; end
        else if (op == 1 || op == 2) begin rem = arg + 1; m_mode = (op == 1); end
        else begin rem = 1; m_err = 1; end
      end
      if (cmd_valid && pre_ready) q.push_back(int'(cmd_op) * 16 + int'(cmd_arg));
    end
  end

  task automatic chk(input string tag, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    chk("load", load, m_load);
    chk("mode", mode, m_mode);
    chk("data_in", data_in, m_data);
    chk("busy", busy, (rem > 0 || q.size() > 0) ? 1 : 0);
    chk("cmd_ready", cmd_ready, (!reset && q.size() < D) ? 1 : 0);
    chk("err_illegal", err_illegal, m_err);
    chk("exp_count", exp_count, PRED ? cnt : 0);
    chk("mismatch_err", mismatch_err, m_mism);
    data_out = 4'(glitch ? (cnt + 1) % 12 : cnt);
  endtask

  task automatic idle(input int n);
    cmd_valid = 0;
    repeat (n) step();
  endtask

  task automatic push(input int op, input int arg);
    bit acc;
    int guard = 0;
    cmd_valid = 1;
    cmd_op = 2'(op);
    cmd_arg = 4'(arg);
    do begin
      acc = q.size() < D;
      step();
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic do_reset();
    cmd_valid = 0;
    reset = 1;
    step();
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_mode", mode, 1);
    chk("rst_data_in", data_in, 0);
    chk("rst_ready", cmd_ready, 0);
    reset = 0;
    step();
    chk("post_rst_ready", cmd_ready, 1);
  endtask

  initial begin
    step();
    do_reset();
    push(0, 5); push(1, 3); idle(8);
    push(0, 1); push(2, 2); idle(6);
    push(1, 15);
    push(0, 2); push(1, 1); push(2, 0); push(0, 7); push(1, 2);
    idle(30);
    push(0, 12); push(3, 0); push(0, 3); idle(5);
    chk("err_sticky", err_illegal, 1);
    push(1, 10); push(0, 4); push(2, 1); idle(3);
    do_reset();
    idle(3);
    push(0, 6); idle(3);
    glitch = 1; step(); glitch = 0;
    idle(3);
    chk("mism_sticky", mismatch_err, PRED ? 1 : 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_op = 2'($urandom_range(0, 3));
      cmd_arg = 4'($urandom_range(0, 15));
      glitch = ($urandom_range(0, 60) == 0);
      reset = ($urandom_range(0, 120) == 0);
      step();
    end
    reset = 0; glitch = 0;
    idle(60);
    chk("drained_busy", busy, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
